md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler beside the E-stage ALU of the P6 pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, latches operands and runs a fixed-latency busy countdown.
- Commits HI/LO at completion and generates the D-stage stall for HI/LO-using instructions while busy.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  E-stage holds a valid MD instruction this cycle
md_op  input  3  `MD_MULT, `MD_MULTU, `MD_DIV, `MD_DIVU, `MD_MTHI, `MD_MTLO
inputA  input  32  forwarded rs value (dividend / multiplicand / MT source)
inputB  input  32  forwarded rt value (divisor / multiplier)
md_use_d  input  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
busy  output  1  operation in flight
md_stall  output  1  stall request to hazard unit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (sync, high): state=IDLE, cnt=0, busy=0, hi=0, lo=0, latched operands=0. Reset mid-operation aborts with no HI/LO write.
- States:
  - IDLE
  - RUN_MUL
  - RUN_DIV
- IDLE, start=1 at edge N, op MULT/MULTU: latch inputA/inputB/op, cnt<=MULT_CYCLES, go RUN_MUL. DIV/DIVU: same with DIV_CYCLES, go RUN_DIV.
- RUN_*: busy=1. cnt decrements each edge. On the edge where cnt==1: write HI/LO, go IDLE, cnt=0.
- busy is high for exactly LAT cycles, N+1..N+LAT. New HI/LO are visible from cycle N+LAT+1, the same cycle busy is low.
- MTHI/MTLO in IDLE: write hi (resp. lo) with inputA at edge N, visible at N+1. No busy.
- start while busy: ignored entirely. The pipeline guarantees this does not occur; the verifier asserts it.
- md_stall = md_use_d & (busy | start). Combinational, no register.
- hi/lo hold their old values throughout RUN_*.
- Arithmetic, 32-bit operands, 64-bit results:
  - MULT: signed product; hi = [63:32], lo = [31:0].
  - MULTU: unsigned product; hi = [63:32], lo = [31:0].
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned; lo = quotient, hi = remainder.
- Boundary cases:
  - Divisor 0 (DIV or DIVU): full latency, busy behaves normally, hi/lo unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Results are computed from the latched operands. Changes on inputA/inputB after edge N have no effect.
- Reset takes priority over completion and over start in the same cycle.

Decomposition:
- Shared header head.v gains the `MD_* op encodings (3-bit) and the state encodings `MDS_IDLE, `MDS_RUN_MUL, `MDS_RUN_DIV.
- One combinational sub-module, md_compute:
  - inputs: latched op, A, B
  - outputs: 64-bit {hi,lo} result and a result-valid flag (0 on divide-by-zero)
  - includes the signed-division sign fix-ups.
- md_sched keeps the FSM, the counter, the operand latches and HI/LO.

Test Plan:
- MULT A=0xFFFFFFFF, B=2: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands gives hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2: busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 gives lo=3, hi=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles: hi/lo update after 1 cycle each, busy never asserts. Then DIVU by 0: busy 10 cycles, hi/lo still 0x12345678/0x9ABCDEF0.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Toggling inputA/inputB during busy does not change the result.
- MULT started, md_use_d=1 throughout:
  - md_stall high on the start cycle and all 5 busy cycles
  - md_stall low on cycle 7
  - md_use_d=0 forces md_stall=0 regardless of busy.
- Reset pulsed at busy cycle 3 of a DIV: the next cycle has busy=0, hi=lo=0, state IDLE. A following MULT 3*4 gives lo=12, hi=0 with full latency.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states,
// counter width and a small magnitude helper used by the signed divider.
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE    = 2'd0,
    MDS_RUN_MUL = 2'd1,
    MDS_RUN_DIV = 2'd2
  } mds_state_e;

  localparam int unsigned CNT_W = 4;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. Produces the {hi,lo} pair for the
// latched operation and a valid flag that is low on divide-by-zero.
module md_compute
  import md_sched_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        valid
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_sdiv;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One shared unsigned divider; signed division runs on magnitudes and the
  // signs are restored afterwards (quotient toward zero, remainder follows
  // the dividend). A zero divisor is steered to 1 so the divider never sees 0.
  assign is_sdiv  = (op == MD_DIV);
  assign num      = is_sdiv ? abs32(a) : a;
  assign den      = is_sdiv ? abs32(b) : b;
  assign den_safe = (den == '0) ? 32'd1 : den;
  assign q_mag    = num / den_safe;
  assign r_mag    = num % den_safe;
  assign quot     = (is_sdiv && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = (is_sdiv && a[31]) ? (~r_mag + 32'd1) : r_mag;

  // Select the result for the latched op.
  always_comb begin
    result = '0;
    valid  = 1'b0;
    unique case (op)
      MD_MULT: begin
        result = prod_s;
        valid  = 1'b1;
      end
      MD_MULTU: begin
        result = prod_u;
        valid  = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        result = {rem, quot};
        valid  = (b != '0);
      end
      default: begin
        result = '0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler: latches operands from E, counts a
// fixed busy latency, commits HI/LO at completion and raises the D-stage
// stall for HI/LO users while an operation is in flight.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  input  logic        md_use_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mds_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  md_op_e           op_in;
  logic [63:0]      result;
  logic             res_valid;

  assign op_in = md_op_e'(md_op);

  md_compute u_md_compute (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result),
    .valid  (res_valid)
  );

  // Next-state, counter, operand latch and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      MDS_IDLE: begin
        if (start) begin
          unique case (op_in)
            MD_MULT, MD_MULTU: begin
              op_d    = op_in;
              a_d     = inputA;
              b_d     = inputB;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = MDS_RUN_MUL;
            end
            MD_DIV, MD_DIVU: begin
              op_d    = op_in;
              a_d     = inputA;
              b_d     = inputB;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = MDS_RUN_DIV;
            end
            MD_MTHI: hi_d = inputA;
            MD_MTLO: lo_d = inputA;
            default: ;
          endcase
        end
      end
      MDS_RUN_MUL, MDS_RUN_DIV: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MDS_IDLE;
          cnt_d   = '0;
          if (res_valid) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MDS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset wins over start and completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDS_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != MDS_IDLE);
  assign md_stall = md_use_d & (busy | start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched with a HI/LO scoreboard.
module tb_md_sched;
  import md_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic        md_use_d;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .inputA   (inputA),
    .inputB   (inputB),
    .md_use_d (md_use_d),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // The pipeline never issues while busy; flag it if the bench ever does.
  always @(posedge clk) begin
    if (!reset && start && busy) begin
      miscompares++;
      $error("FAIL start_while_busy: observed start=1 busy=1 required start=0");
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written with native signed arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    logic signed [31:0] qs;
    logic signed [31:0] rs;
    case (op)
      3'd0: return 64'($signed(a)) * 64'($signed(b));
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {h, l};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qs = $signed(a) / $signed(b);
        rs = $signed(a) % $signed(b);
        return {rs, qs};
      end
      3'd3: begin
        if (b == 32'd0) return {h, l};
        return {a % b, a / b};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic use_d,
                        input logic scramble);
    exp_t        e;
    logic [63:0] r;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
    old_hi = mhi;
    old_lo = mlo;
    r      = model(op, a, b, mhi, mlo);
    e.tag  = tag;
    e.hi   = r[63:32];
    e.lo   = r[31:0];
    sb.push_back(e);
    mhi    = r[63:32];
    mlo    = r[31:0];

    md_use_d = use_d;
    md_op    = op;
    inputA   = a;
    inputB   = b;
    start    = 1'b1;
    #1;
    check({tag, "_stall_start"}, 64'(md_stall), 64'(use_d));
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      check({tag, "_stall_busy"}, 64'(md_stall), 64'(use_d));
      check({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
      if (scramble) begin
        inputA = $urandom;
        inputB = $urandom;
      end
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    if (use_d) check({tag, "_stall_after"}, 64'(md_stall), 64'd0);
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 3'd0;
    inputA   = '0;
    inputB   = '0;
    md_use_d = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    run_op("mult_neg1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu_neg1x2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0);
    check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 1'b0);
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2, 10, 1'b0, 1'b0);
    check("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);

    run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, 0, 1'b0, 1'b0);
    run_op("mtlo", MD_MTLO, 32'h9ABC_DEF0, 32'd0, 0, 1'b0, 1'b0);
    run_op("divu_by0", MD_DIVU, 32'd55, 32'd0, 10, 1'b0, 1'b0);
    check("divu_by0_const", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    run_op("div_by0", MD_DIV, 32'hFFFF_0000, 32'd0, 10, 1'b0, 1'b0);

    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 1'b1);
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_scramble", MD_DIVU, 32'd100, 32'd7, 10, 1'b0, 1'b1);

    run_op("mult_stall", MD_MULT, 32'd9, 32'hFFFF_FFFD, 5, 1'b1, 1'b0);
    run_op("mult_nostall", MD_MULT, 32'd6, 32'd7, 5, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'h7FFF_FFFF);
      run_op("rand_mult", MD_MULT, ra, rb, 5, 1'b0, 1'b0);
      run_op("rand_multu", MD_MULTU, rb, ra, 5, 1'b0, 1'b0);
      run_op("rand_div", MD_DIV, ra, (i[0] ? ~rb : rb), 10, 1'b0, 1'b0);
      run_op("rand_divu", MD_DIVU, ra, rb >> i, 10, 1'b0, 1'b0);
    end

    // Abort a DIV with reset on its third busy cycle.
    md_op  = MD_DIV;
    inputA = 32'd1000;
    inputB = 32'd3;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 3) begin
      n++;
      if (n < 3) begin
        @(posedge clk); #1;
      end
    end
    check("abort_reached_cycle3", 64'(n), 64'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mhi = '0;
    mlo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    check("abort_stays_idle", 64'(busy), 64'd0);
    run_op("mult_3x4", MD_MULT, 32'd3, 32'd4, 5, 1'b0, 1'b0);
    check("mult_3x4_const", {hi, lo}, 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
